// File: rtl/pmem_seq.sv
// OTP program-memory access sequencer: arbitrates CPU reads against byte programming
// on two byte-wide OTP macros and generates their registered control waveforms.
module pmem_seq #(
  parameter int unsigned T_RD  = 2,
  parameter int unsigned T_SU  = 4,
  parameter int unsigned T_PGM = 100
) (
  input  logic        i_clk,
  input  logic        i_rstz,
  input  logic        rd_req,
  input  logic [15:0] rd_addr,
  output logic        rd_ack,
  output logic [15:0] rd_data,
  input  logic        pg_req,
  input  logic [15:0] pg_addr,
  input  logic        pg_sel,
  input  logic [7:0]  pg_data,
  input  logic        pg_en,
  output logic        pg_ack,
  output logic        pg_ok,
  output logic        busy,
  output logic [15:0] PMEM_A,
  output logic        PMEM_CSB,
  output logic        PMEM_RE,
  output logic        PMEM_PGM,
  output logic [1:0]  PMEM_CLK,
  output logic [1:0]  PMEM_TWLB,
  output logic [1:0]  PMEM_SAP,
  input  logic [7:0]  PMEM_Q0,
  input  logic [7:0]  PMEM_Q1
);

  typedef enum logic [3:0] {
    IDLE, RD_SU, RD_CLK, RD_WAIT, PG_SU, PG_PULSE, PG_HOLD,
    VF_SU, VF_CLK, VF_WAIT, DONE
  } state_t;

  localparam logic [9:0] CNT_RD  = 10'(T_RD);
  localparam logic [9:0] CNT_SU  = 10'(T_SU);
  localparam logic [9:0] CNT_PGM = 10'(T_PGM);

  state_t      state, state_n;
  logic [9:0]  cnt, cnt_n;
  logic        last_pg;
  logic        sel_q, sel_n;
  logic        abort_q, abort_n;
  logic [7:0]  exp_q;
  logic        rd_vld, pg_vld, grant_rd, grant_pg;
  logic        last_cyc;
  logic [7:0]  vf_byte;
  logic        csb_n, re_n, pgm_n;
  logic [1:0]  clk_n, twlb_n, sap_n;

  assign busy     = (state != IDLE);
  assign last_cyc = (cnt == 10'd1);
  assign vf_byte  = sel_q ? PMEM_Q1 : PMEM_Q0;

  // A port whose ack is showing is masked so its still-high request is not re-granted.
  always_comb begin
    rd_vld   = rd_req & ~rd_ack;
    pg_vld   = pg_req & ~pg_ack;
    grant_rd = 1'b0;
    grant_pg = 1'b0;
    if (state == IDLE) begin
      if (rd_vld && pg_vld) begin
        grant_rd = last_pg;
        grant_pg = ~last_pg;
      end else begin
        grant_rd = rd_vld;
        grant_pg = pg_vld;
      end
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel_q;
    abort_n = abort_q;
    case (state)
      IDLE: begin
        if (grant_rd) begin
          state_n = RD_SU;
        end else if (grant_pg) begin
          sel_n   = pg_sel;
          abort_n = 1'b0;
          state_n = pg_en ? PG_SU : DONE;
        end
      end
      RD_SU:   state_n = RD_CLK;
      RD_CLK:  state_n = RD_WAIT;
      RD_WAIT: if (last_cyc) state_n = IDLE;
      PG_SU: begin
        if (!pg_en) begin
          abort_n = 1'b1;
          state_n = PG_HOLD;
        end else if (last_cyc) begin
          state_n = PG_PULSE;
        end
      end
      PG_PULSE: begin
        if (!pg_en) begin
          abort_n = 1'b1;
          state_n = PG_HOLD;
        end else if (last_cyc) begin
          state_n = PG_HOLD;
        end
      end
      PG_HOLD: if (last_cyc) state_n = abort_q ? DONE : VF_SU;
      VF_SU:   state_n = VF_CLK;
      VF_CLK:  state_n = VF_WAIT;
      VF_WAIT: if (last_cyc) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cnt_n = cnt;
    if (state_n != state) begin
      case (state_n)
        PG_SU, PG_HOLD:   cnt_n = CNT_SU;
        PG_PULSE:         cnt_n = CNT_PGM;
        RD_WAIT, VF_WAIT: cnt_n = CNT_RD;
        default:          cnt_n = 10'd1;
      endcase
    end else if (cnt > 10'd1) begin
      cnt_n = cnt - 10'd1;
    end
  end

  // Strobes are decoded from the next state and registered, so they line up with the state.
  always_comb begin
    csb_n  = 1'b1;
    re_n   = 1'b0;
    pgm_n  = 1'b0;
    clk_n  = 2'b00;
    twlb_n = 2'b11;
    sap_n  = 2'b00;
    case (state_n)
      RD_SU, VF_SU: begin
        csb_n = 1'b0;
        re_n  = 1'b1;
      end
      RD_CLK, VF_CLK: begin
        csb_n = 1'b0;
        re_n  = 1'b1;
        clk_n = 2'b11;
        sap_n = 2'b11;
      end
      RD_WAIT, VF_WAIT: begin
        csb_n = 1'b0;
        re_n  = 1'b1;
        sap_n = 2'b11;
      end
      PG_SU, PG_HOLD: begin
        csb_n  = 1'b0;
        pgm_n  = 1'b1;
        twlb_n = sel_n ? 2'b01 : 2'b10;
      end
      PG_PULSE: begin
        csb_n  = 1'b0;
        pgm_n  = 1'b1;
        twlb_n = sel_n ? 2'b01 : 2'b10;
        clk_n  = sel_n ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstz) begin
    if (!i_rstz) begin
      state     <= IDLE;
      cnt       <= '0;
      last_pg   <= 1'b1;
      sel_q     <= 1'b0;
      abort_q   <= 1'b0;
      exp_q     <= '0;
      rd_ack    <= 1'b0;
      rd_data   <= '0;
      pg_ack    <= 1'b0;
      pg_ok     <= 1'b0;
      PMEM_A    <= '0;
      PMEM_CSB  <= 1'b1;
      PMEM_RE   <= 1'b0;
      PMEM_PGM  <= 1'b0;
      PMEM_CLK  <= 2'b00;
      PMEM_TWLB <= 2'b11;
      PMEM_SAP  <= 2'b00;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sel_q     <= sel_n;
      abort_q   <= abort_n;
      PMEM_CSB  <= csb_n;
      PMEM_RE   <= re_n;
      PMEM_PGM  <= pgm_n;
      PMEM_CLK  <= clk_n;
      PMEM_TWLB <= twlb_n;
      PMEM_SAP  <= sap_n;
      if (grant_rd) begin
        PMEM_A  <= rd_addr;
        last_pg <= 1'b0;
      end else if (grant_pg) begin
        last_pg <= 1'b1;
        exp_q   <= pg_data;
        if (pg_en) PMEM_A <= pg_addr;
      end
      rd_ack <= (state == RD_WAIT) && last_cyc;
      if ((state == RD_WAIT) && last_cyc) rd_data <= {PMEM_Q1, PMEM_Q0};
      pg_ack <= (state_n == DONE);
      if (state_n == DONE) pg_ok <= (state == VF_WAIT) && (vf_byte == exp_q);
    end
  end

endmodule

// File: tb/tb_pmem_seq.sv
// Directed self-checking bench for pmem_seq: reads, arbitration, programming,
// disabled/aborted programming and asynchronous reset mid-operation.
module tb_pmem_seq;

  logic        clk = 1'b0;
  logic        rstz;
  logic        rd_req, pg_req, pg_sel, pg_en;
  logic [15:0] rd_addr, pg_addr;
  logic [7:0]  pg_data, q0, q1;
  logic        rd_ack, pg_ack, pg_ok, busy;
  logic [15:0] rd_data, pmem_a;
  logic        pmem_csb, pmem_re, pmem_pgm;
  logic [1:0]  pmem_clk, pmem_twlb, pmem_sap;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pmem_seq #(.T_RD(2), .T_SU(4), .T_PGM(100)) dut (
    .i_clk(clk), .i_rstz(rstz),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .pg_req(pg_req), .pg_addr(pg_addr), .pg_sel(pg_sel), .pg_data(pg_data),
    .pg_en(pg_en), .pg_ack(pg_ack), .pg_ok(pg_ok), .busy(busy),
    .PMEM_A(pmem_a), .PMEM_CSB(pmem_csb), .PMEM_RE(pmem_re), .PMEM_PGM(pmem_pgm),
    .PMEM_CLK(pmem_clk), .PMEM_TWLB(pmem_twlb), .PMEM_SAP(pmem_sap),
    .PMEM_Q0(q0), .PMEM_Q1(q1)
  );

  // Drives one read and records what the macro pins did; starts and ends on a negedge.
  task automatic run_read(input logic [15:0] addr, output int ack_at, output int csb_low,
                          output int re_hi, output int clk_hi, output logic [15:0] a_seen);
    rd_addr = addr; rd_req = 1'b1;
    ack_at = 0; csb_low = 0; re_hi = 0; clk_hi = 0; a_seen = '0;
    for (int k = 1; k <= 20 && ack_at == 0; k++) begin
      @(negedge clk);
      if (k == 1) rd_addr = 16'hFFFF;
      if (k == 3) a_seen = pmem_a;
      if (!pmem_csb) csb_low++;
      if (pmem_re) re_hi++;
      if (pmem_clk == 2'b11) clk_hi++;
      if (rd_ack) begin ack_at = k; rd_req = 1'b0; end
    end
  endtask

  // Drives one program request; drop_at > 0 lowers pg_en after that many pulse cycles.
  task automatic run_prog(input logic sel, input logic [7:0] data, input logic en, input int drop_at,
                          output int ack_at, output logic ok, output int sel_hi, output int oth_hi,
                          output int twlb_bad, output int pgm_cnt, output int re_cnt,
                          output int csb_cnt, output logic [1:0] clk_after);
    logic [1:0] sel_mask;
    int drop_k;
    sel_mask = sel ? 2'b10 : 2'b01;
    pg_sel = sel; pg_data = data; pg_en = en; pg_addr = 16'h00C3; pg_req = 1'b1;
    ack_at = 0; ok = 1'bx; sel_hi = 0; oth_hi = 0; twlb_bad = 0; pgm_cnt = 0;
    re_cnt = 0; csb_cnt = 0; clk_after = 2'bxx; drop_k = 0;
    for (int k = 1; k <= 200 && ack_at == 0; k++) begin
      @(negedge clk);
      if (k == 1) pg_data = ~data;
      if (drop_k != 0 && k == drop_k + 1) clk_after = pmem_clk;
      if (pmem_pgm) begin
        pgm_cnt++;
        if (pmem_twlb != ~sel_mask) twlb_bad++;
        if ((pmem_clk & ~sel_mask) != 2'b00) oth_hi++;
        if ((pmem_clk & sel_mask) != 2'b00) sel_hi++;
      end
      if (pmem_re) re_cnt++;
      if (!pmem_csb) csb_cnt++;
      if (pg_ack) begin ack_at = k; ok = pg_ok; pg_req = 1'b0; end
      if (drop_at != 0 && drop_k == 0 && sel_hi == drop_at) begin pg_en = 1'b0; drop_k = k; end
    end
  endtask

  // Raises the chosen requests together (pg_en low) and records each ack cycle.
  task automatic run_pair(input logic do_rd, input logic do_pg, output int rd_at, output int pg_at);
    rd_addr = 16'h0042; pg_en = 1'b0; rd_req = do_rd; pg_req = do_pg;
    rd_at = 0; pg_at = 0;
    for (int k = 1; k <= 40 && ((do_rd && rd_at == 0) || (do_pg && pg_at == 0)); k++) begin
      @(negedge clk);
      if (rd_ack && rd_at == 0) begin rd_at = k; rd_req = 1'b0; end
      if (pg_ack && pg_at == 0) begin pg_at = k; pg_req = 1'b0; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rstz = 1'b0;
    repeat (2) @(negedge clk);
    rstz = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstz = 1'b0; rd_req = 1'b0; pg_req = 1'b0; pg_en = 1'b1; pg_sel = 1'b0;
    rd_addr = '0; pg_addr = '0; pg_data = '0; q0 = '0; q1 = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (pmem_csb !== 1'b1) $display("FAIL reset_csb got=%b exp=1", pmem_csb); else n_pass++;
    n_checks++; if ({pmem_re, pmem_pgm} !== 2'b00) $display("FAIL reset_re_pgm got=%b exp=00", {pmem_re, pmem_pgm}); else n_pass++;
    n_checks++; if ({pmem_clk, pmem_twlb, pmem_sap} !== 6'b001100) $display("FAIL reset_clk_twlb_sap got=%b exp=001100", {pmem_clk, pmem_twlb, pmem_sap}); else n_pass++;
    n_checks++; if (pmem_a !== 16'h0000) $display("FAIL reset_addr got=%h exp=0000", pmem_a); else n_pass++;
    n_checks++; if ({rd_ack, pg_ack, pg_ok, busy} !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", {rd_ack, pg_ack, pg_ok, busy}); else n_pass++;
    n_checks++; if (rd_data !== 16'h0000) $display("FAIL reset_rd_data got=%h exp=0000", rd_data); else n_pass++;
    rstz = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    int ack_at, csb_low, re_hi, clk_hi;
    logic [15:0] a_seen;
    q1 = 8'hA5; q0 = 8'h3C;
    run_read(16'h1234, ack_at, csb_low, re_hi, clk_hi, a_seen);
    n_checks++; if (ack_at !== 5) $display("FAIL read_latency got=%0d exp=5", ack_at); else n_pass++;
    n_checks++; if (rd_data !== 16'hA53C) $display("FAIL read_data got=%h exp=a53c", rd_data); else n_pass++;
    n_checks++; if (a_seen !== 16'h1234) $display("FAIL read_addr got=%h exp=1234", a_seen); else n_pass++;
    n_checks++; if (csb_low !== 4) $display("FAIL read_csb_window got=%0d exp=4", csb_low); else n_pass++;
    n_checks++; if (re_hi !== 4) $display("FAIL read_re_window got=%0d exp=4", re_hi); else n_pass++;
    n_checks++; if (clk_hi !== 1) $display("FAIL read_clk_width got=%0d exp=1", clk_hi); else n_pass++;
    q1 = 8'h00; q0 = 8'h00;
    @(negedge clk);
    n_checks++; if ({rd_ack, busy} !== 2'b00) $display("FAIL read_after_ack got=%b exp=00", {rd_ack, busy}); else n_pass++;
    n_checks++; if (rd_data !== 16'hA53C) $display("FAIL read_data_hold got=%h exp=a53c", rd_data); else n_pass++;
  endtask

  task automatic test_arbitration();
    int rd_at, pg_at;
    do_reset();
    run_pair(1'b1, 1'b1, rd_at, pg_at);
    n_checks++; if ({rd_at, pg_at} !== {32'd5, 32'd6}) $display("FAIL arb_first_tie got=rd%0d/pg%0d exp=rd5/pg6", rd_at, pg_at); else n_pass++;
    run_pair(1'b1, 1'b1, rd_at, pg_at);
    n_checks++; if ({rd_at, pg_at} !== {32'd5, 32'd6}) $display("FAIL arb_second_tie got=rd%0d/pg%0d exp=rd5/pg6", rd_at, pg_at); else n_pass++;
    run_pair(1'b1, 1'b0, rd_at, pg_at);
    n_checks++; if (rd_at !== 5) $display("FAIL arb_read_only got=%0d exp=5", rd_at); else n_pass++;
    run_pair(1'b1, 1'b1, rd_at, pg_at);
    n_checks++; if ({rd_at, pg_at} !== {32'd7, 32'd1}) $display("FAIL arb_tie_after_read got=rd%0d/pg%0d exp=rd7/pg1", rd_at, pg_at); else n_pass++;
  endtask

  task automatic test_program();
    int ack_at, sel_hi, oth_hi, twlb_bad, pgm_cnt, re_cnt, csb_cnt;
    logic ok;
    logic [1:0] clk_after;
    q1 = 8'h5A; q0 = 8'h00;
    run_prog(1'b1, 8'h5A, 1'b1, 0, ack_at, ok, sel_hi, oth_hi, twlb_bad, pgm_cnt, re_cnt, csb_cnt, clk_after);
    n_checks++; if (ack_at !== 113) $display("FAIL prog_latency got=%0d exp=113", ack_at); else n_pass++;
    n_checks++; if (ok !== 1'b1) $display("FAIL prog_ok_pass got=%b exp=1", ok); else n_pass++;
    n_checks++; if (sel_hi !== 100) $display("FAIL prog_pulse_width got=%0d exp=100", sel_hi); else n_pass++;
    n_checks++; if (oth_hi !== 0) $display("FAIL prog_other_clk got=%0d exp=0", oth_hi); else n_pass++;
    n_checks++; if (twlb_bad !== 0) $display("FAIL prog_twlb got=%0d exp=0", twlb_bad); else n_pass++;
    n_checks++; if (pgm_cnt !== 108) $display("FAIL prog_pgm_window got=%0d exp=108", pgm_cnt); else n_pass++;
    n_checks++; if (re_cnt !== 4) $display("FAIL prog_verify_re got=%0d exp=4", re_cnt); else n_pass++;
    @(negedge clk);
    n_checks++; if ({pg_ack, pg_ok} !== 2'b01) $display("FAIL prog_ok_hold got=%b exp=01", {pg_ack, pg_ok}); else n_pass++;
    q1 = 8'h58;
    run_prog(1'b1, 8'h5A, 1'b1, 0, ack_at, ok, sel_hi, oth_hi, twlb_bad, pgm_cnt, re_cnt, csb_cnt, clk_after);
    n_checks++; if (ack_at !== 113) $display("FAIL prog_fail_latency got=%0d exp=113", ack_at); else n_pass++;
    n_checks++; if (ok !== 1'b0) $display("FAIL prog_ok_mismatch got=%b exp=0", ok); else n_pass++;
    @(negedge clk);
    q1 = 8'h5A; q0 = 8'hC3;
    run_prog(1'b0, 8'hC3, 1'b1, 0, ack_at, ok, sel_hi, oth_hi, twlb_bad, pgm_cnt, re_cnt, csb_cnt, clk_after);
    n_checks++; if (ok !== 1'b1) $display("FAIL prog_q0_ok got=%b exp=1", ok); else n_pass++;
    n_checks++; if ({sel_hi, oth_hi, twlb_bad} !== {32'd100, 32'd0, 32'd0}) $display("FAIL prog_q0_wave got=hi%0d/oth%0d/twlb%0d exp=hi100/oth0/twlb0", sel_hi, oth_hi, twlb_bad); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_pg_disabled();
    int ack_at, sel_hi, oth_hi, twlb_bad, pgm_cnt, re_cnt, csb_cnt;
    logic ok;
    logic [1:0] clk_after;
    run_prog(1'b1, 8'h5A, 1'b0, 0, ack_at, ok, sel_hi, oth_hi, twlb_bad, pgm_cnt, re_cnt, csb_cnt, clk_after);
    n_checks++; if (ack_at !== 1) $display("FAIL dis_latency got=%0d exp=1", ack_at); else n_pass++;
    n_checks++; if (ok !== 1'b0) $display("FAIL dis_ok got=%b exp=0", ok); else n_pass++;
    n_checks++; if ({csb_cnt, pgm_cnt} !== {32'd0, 32'd0}) $display("FAIL dis_no_activity got=csb%0d/pgm%0d exp=csb0/pgm0", csb_cnt, pgm_cnt); else n_pass++;
    pg_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int ack_at, sel_hi, oth_hi, twlb_bad, pgm_cnt, re_cnt, csb_cnt;
    logic ok;
    logic [1:0] clk_after;
    q1 = 8'h77;
    run_prog(1'b1, 8'h77, 1'b1, 0, ack_at, ok, sel_hi, oth_hi, twlb_bad, pgm_cnt, re_cnt, csb_cnt, clk_after);
    n_checks++; if (ok !== 1'b1) $display("FAIL abort_prelude_ok got=%b exp=1", ok); else n_pass++;
    @(negedge clk);
    run_prog(1'b1, 8'h77, 1'b1, 50, ack_at, ok, sel_hi, oth_hi, twlb_bad, pgm_cnt, re_cnt, csb_cnt, clk_after);
    n_checks++; if (clk_after !== 2'b00) $display("FAIL abort_clk_drop got=%b exp=00", clk_after); else n_pass++;
    n_checks++; if (sel_hi !== 50) $display("FAIL abort_pulse_width got=%0d exp=50", sel_hi); else n_pass++;
    n_checks++; if (ack_at !== 59) $display("FAIL abort_latency got=%0d exp=59", ack_at); else n_pass++;
    n_checks++; if (ok !== 1'b0) $display("FAIL abort_ok got=%b exp=0", ok); else n_pass++;
    n_checks++; if (re_cnt !== 0) $display("FAIL abort_no_verify got=%0d exp=0", re_cnt); else n_pass++;
    n_checks++; if (pgm_cnt !== 58) $display("FAIL abort_pgm_window got=%0d exp=58", pgm_cnt); else n_pass++;
    pg_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int ack_at, csb_low, re_hi, clk_hi, acks;
    logic [15:0] a_seen;
    pg_sel = 1'b1; pg_data = 8'h11; pg_en = 1'b1; pg_addr = 16'h0BAD; pg_req = 1'b1;
    repeat (30) @(negedge clk);
    n_checks++; if ({pmem_pgm, pmem_clk, pmem_twlb} !== 5'b11001) $display("FAIL rst_mid_before got=%b exp=11001", {pmem_pgm, pmem_clk, pmem_twlb}); else n_pass++;
    rstz = 1'b0;
    #1;
    n_checks++; if ({pmem_pgm, pmem_clk, pmem_twlb} !== 5'b00011) $display("FAIL rst_mid_async got=%b exp=00011", {pmem_pgm, pmem_clk, pmem_twlb}); else n_pass++;
    n_checks++; if ({pmem_csb, busy, pmem_a} !== {1'b1, 1'b0, 16'h0000}) $display("FAIL rst_mid_csb_busy_addr got=%b/%b/%h exp=1/0/0000", pmem_csb, busy, pmem_a); else n_pass++;
    pg_req = 1'b0;
    repeat (2) @(negedge clk);
    rstz = 1'b1;
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      if (pg_ack) acks++;
    end
    n_checks++; if (acks !== 0) $display("FAIL rst_mid_no_ack got=%0d exp=0", acks); else n_pass++;
    q1 = 8'h12; q0 = 8'h34;
    run_read(16'hBEEF, ack_at, csb_low, re_hi, clk_hi, a_seen);
    n_checks++; if (ack_at !== 5) $display("FAIL rst_mid_read_latency got=%0d exp=5", ack_at); else n_pass++;
    n_checks++; if (rd_data !== 16'h1234) $display("FAIL rst_mid_read_data got=%h exp=1234", rd_data); else n_pass++;
    n_checks++; if (a_seen !== 16'hBEEF) $display("FAIL rst_mid_read_addr got=%h exp=beef", a_seen); else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_arbitration();
    test_program();
    test_pg_disabled();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
